// File: rtl/pipeline_stage_buf.sv
// Elastic pipeline stage: registered output plus a DEPTH-entry FIFO skid buffer,
// with flush propagation, occupancy-driven backpressure and sticky overflow.
module pipeline_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SKID  = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_stall,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_flush,
  output logic             out_stall,
  output logic [CW-1:0]    occupancy,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - SKID);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             buf_nonempty;
  logic             adv;
  logic             fire;
  logic             deq;
  logic             acc;
  logic             enq;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    buf_nonempty = (occupancy != '0);
    adv          = !(out_valid && in_stall);
    fire         = adv && (in_valid || buf_nonempty);
    deq          = fire && buf_nonempty;
    acc          = in_valid && ((occupancy < FULL_LVL) || deq);
    enq          = acc && (buf_nonempty || !fire);
  end

  assign out_stall = (occupancy >= STALL_LVL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_flush <= 1'b0;
      occupancy <= '0;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (in_flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_flush <= 1'b1;
      occupancy <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      out_flush <= 1'b0;
      if (adv) begin
        out_valid <= fire;
      end
      // Buffered beats always leave before the bypass path to keep ordering.
      if (fire) begin
        out_data <= buf_nonempty ? mem[rd_ptr] : in_data;
      end
      if (deq) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      if (enq) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (enq && !deq) begin
        occupancy <= occupancy + 1'b1;
      end else if (deq && !enq) begin
        occupancy <= occupancy - 1'b1;
      end
      if (in_valid && !acc) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !in_flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_buf.sv
// Bench for pipeline_stage_buf: a queue-based model of two instances (DEPTH=4 and
// DEPTH=3) checked every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_pipeline_stage_buf;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       a_flush = 0, a_valid = 0, a_stall = 0;
  logic [7:0] a_data = 0;
  logic [7:0] a_odata;
  logic       a_ovalid, a_oflush, a_ostall, a_ovf;
  logic [2:0] a_occ;

  logic       b_flush = 0, b_valid = 0, b_stall = 0;
  logic [7:0] b_data = 0;
  logic [7:0] b_odata;
  logic       b_ovalid, b_oflush, b_ostall, b_ovf;
  logic [1:0] b_occ;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [2][$];
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  logic       m_flush [2];
  logic       m_ovf   [2];
  int         b_enq_count = 0;

  always #5 clk = ~clk;

  pipeline_stage_buf #(.WIDTH(8), .DEPTH(4), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .in_flush(a_flush), .in_data(a_data),
    .in_valid(a_valid), .in_stall(a_stall), .out_data(a_odata),
    .out_valid(a_ovalid), .out_flush(a_oflush), .out_stall(a_ostall),
    .occupancy(a_occ), .overflow(a_ovf)
  );

  pipeline_stage_buf #(.WIDTH(8), .DEPTH(3), .SKID(1)) dut_b (
    .clk(clk), .reset(reset), .in_flush(b_flush), .in_data(b_data),
    .in_valid(b_valid), .in_stall(b_stall), .out_data(b_odata),
    .out_valid(b_ovalid), .out_flush(b_oflush), .out_stall(b_ostall),
    .occupancy(b_occ), .overflow(b_ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_valid[k] = 0;
      m_data[k]  = 0;
      m_flush[k] = 0;
      m_ovf[k]   = 0;
    end
  endtask

  // One beat-level step: the output slot moves if it is empty or downstream takes it,
  // refilling from the queue head first, else straight from the input.
  task automatic model_update(input int k, input logic fl, input logic v,
                              input logic [7:0] d, input logic st);
    if (fl) begin
      mq[k].delete();
      m_valid[k] = 0;
      m_data[k]  = 0;
      m_flush[k] = 1;
    end else begin
      m_flush[k] = 0;
      if (!(m_valid[k] && st)) begin
        if (mq[k].size() > 0) begin
          m_data[k]  = mq[k].pop_front();
          m_valid[k] = 1;
          if (v) begin
            mq[k].push_back(d);
            if (k == 1) b_enq_count++;
          end
        end else if (v) begin
          m_data[k]  = d;
          m_valid[k] = 1;
        end else begin
          m_valid[k] = 0;
        end
      end else if (v) begin
        if (mq[k].size() < depth_of(k)) begin
          mq[k].push_back(d);
          if (k == 1) b_enq_count++;
        end else begin
          m_ovf[k] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
    end else begin
      model_update(0, a_flush, a_valid, a_data, a_stall);
      model_update(1, b_flush, b_valid, b_data, b_stall);
    end
  end

  always @(negedge clk) begin
    checkOutput("a_out_data",  32'(a_odata),  32'(m_data[0]));
    checkOutput("a_out_valid", 32'(a_ovalid), 32'(m_valid[0]));
    checkOutput("a_out_flush", 32'(a_oflush), 32'(m_flush[0]));
    checkOutput("a_occupancy", 32'(a_occ),    32'(mq[0].size()));
    checkOutput("a_out_stall", 32'(a_ostall), 32'(mq[0].size() >= 3));
    checkOutput("a_overflow",  32'(a_ovf),    32'(m_ovf[0]));
    checkOutput("b_out_data",  32'(b_odata),  32'(m_data[1]));
    checkOutput("b_out_valid", 32'(b_ovalid), 32'(m_valid[1]));
    checkOutput("b_out_flush", 32'(b_oflush), 32'(m_flush[1]));
    checkOutput("b_occupancy", 32'(b_occ),    32'(mq[1].size()));
    checkOutput("b_out_stall", 32'(b_ostall), 32'(mq[1].size() >= 2));
    checkOutput("b_overflow",  32'(b_ovf),    32'(m_ovf[1]));
  end

  task automatic applyStimulus(input int k, input logic fl, input logic v,
                               input logic [7:0] d, input logic st);
    if (k == 0) begin
      a_flush = fl; a_valid = v; a_data = d; a_stall = st;
    end else begin
      b_flush = fl; b_valid = v; b_data = d; b_stall = st;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] sent [$];
  logic [7:0] received [$];
  logic [7:0] drain_exp [5];
  logic [7:0] cnt;
  logic       st;
  logic       drained;

  initial begin
    model_clear();
    #1;
    checkOutput("reset_data",  32'(a_odata),  0);
    checkOutput("reset_valid", 32'(a_ovalid), 0);
    checkOutput("reset_occ",   32'(a_occ),    0);
    checkOutput("reset_ovf",   32'(a_ovf),    0);
    repeat (2) @(posedge clk);
    #2 reset = 0;

    $display("[TB] stream passthrough");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, 8'(i), 0);
      step();
      checkOutput("pass_data",  32'(a_odata),  32'(i));
      checkOutput("pass_valid", 32'(a_ovalid), 1);
      checkOutput("pass_occ",   32'(a_occ),    0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    step();
    checkOutput("pass_idle_valid", 32'(a_ovalid), 0);

    $display("[TB] stall fill and overflow");
    applyStimulus(0, 0, 1, 8'h9F, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 8'(8'hA0 + i), 1);
      step();
      checkOutput("fill_occ",   32'(a_occ),    32'(i + 1));
      checkOutput("fill_stall", 32'(a_ostall), 32'(i + 1 >= 3));
      checkOutput("fill_hold",  32'(a_odata),  32'h9F);
    end
    applyStimulus(0, 0, 1, 8'hBB, 1);
    step();
    checkOutput("ovf_set", 32'(a_ovf), 1);
    checkOutput("ovf_occ", 32'(a_occ), 4);
    applyStimulus(0, 0, 1, 8'hCC, 0);
    step();
    checkOutput("full_accept_occ",  32'(a_occ),   4);
    checkOutput("full_accept_data", 32'(a_odata), 32'hA0);
    drain_exp = '{8'hA1, 8'hA2, 8'hA3, 8'hCC, 8'h00};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      step();
      checkOutput("drain_data",  32'(a_odata), 32'(drain_exp[i]));
      checkOutput("drain_occ",   32'(a_occ),   32'(3 - i));
      checkOutput("ovf_sticky",  32'(a_ovf),   1);
    end

    $display("[TB] flush mid-stream");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 8'(8'hD1 + i), 1);
      step();
    end
    checkOutput("preflush_occ", 32'(a_occ), 3);
    applyStimulus(0, 1, 1, 8'hEE, 1);
    step();
    checkOutput("flush_occ",   32'(a_occ),    0);
    checkOutput("flush_valid", 32'(a_ovalid), 0);
    checkOutput("flush_data",  32'(a_odata),  0);
    checkOutput("flush_out",   32'(a_oflush), 1);
    applyStimulus(0, 0, 0, 0, 0);
    step();
    checkOutput("flush_clear", 32'(a_oflush), 0);
    checkOutput("flush_ovf",   32'(a_ovf),    1);

    $display("[TB] async reset");
    applyStimulus(0, 0, 1, 8'hE0, 1);
    step();
    applyStimulus(0, 0, 1, 8'hE1, 1);
    step();
    applyStimulus(0, 0, 1, 8'hE2, 1);
    step();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("prereset_occ", 32'(a_occ), 2);
    checkOutput("prereset_ovf", 32'(a_ovf), 1);
    #1 reset = 1;
    #1;
    checkOutput("areset_data",  32'(a_odata),  0);
    checkOutput("areset_valid", 32'(a_ovalid), 0);
    checkOutput("areset_occ",   32'(a_occ),    0);
    checkOutput("areset_ovf",   32'(a_ovf),    0);
    checkOutput("areset_stall", 32'(a_ostall), 0);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 reset = 0;

    $display("[TB] wrap on DEPTH=3 instance");
    cnt = 0;
    for (int i = 0; i < 240; i++) begin
      st = ((i % 5) < 3);
      if (b_ovalid && !st) received.push_back(b_odata);
      if (!b_ostall) begin
        sent.push_back(cnt);
        applyStimulus(1, 0, 1, cnt, st);
        cnt++;
      end else begin
        applyStimulus(1, 0, 0, 0, st);
      end
      step();
    end
    drained = 0;
    for (int i = 0; i < 20 && !drained; i++) begin
      if (!b_ovalid && b_occ == 0) begin
        drained = 1;
      end else begin
        if (b_ovalid) received.push_back(b_odata);
        applyStimulus(1, 0, 0, 0, 0);
        step();
      end
    end
    checkOutput("wrap_drained",  32'(drained), 1);
    checkOutput("wrap_ovf",      32'(b_ovf), 0);
    checkOutput("wrap_wraps",    32'(b_enq_count > 30), 1);
    checkOutput("wrap_count",    32'(received.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < received.size(); i++) begin
      checkOutput("wrap_order", 32'(received[i]), 32'(sent[i]));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
